// File: rtl/d8_pkg.sv
// rtl/d8_pkg.sv - shared op codes, ALU control codes, FSM states and flag indices for d8_exec
package d8_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_SHL  = 3'b011,
        OP_SHR  = 3'b100,
        OP_ADDW = 3'b101,
        OP_SUBW = 3'b110,
        OP_CMP  = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        ALU_NOP = 3'b000,
        ALU_ADD = 3'b001,
        ALU_SUB = 3'b010,
        ALU_SHL = 3'b011,
        ALU_SHR = 3'b100
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LO   = 3'd1,
        HI   = 3'd2,
        FIX  = 3'd3,
        RESP = 3'd4
    } state_e;

    // Flag vectors are ordered {n, o, z, c}
    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_O = 2;
    localparam int FLAG_N = 3;

    function automatic logic [2:0] alu_ctrl_for(input logic [2:0] op);
        logic [2:0] ctrl;
        case (op)
            OP_ADD, OP_ADDW:         ctrl = ALU_ADD;
            OP_SUB, OP_SUBW, OP_CMP: ctrl = ALU_SUB;
            OP_SHL:                  ctrl = ALU_SHL;
            OP_SHR:                  ctrl = ALU_SHR;
            default:                 ctrl = ALU_NOP;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/d8_exec_wflags.sv
// rtl/d8_exec_wflags.sv - merges low, high and carry-fix pass flags into 16-bit result flags
module d8_exec_wflags
    import d8_pkg::*;
(
    input  logic       in_fix,
    input  logic       lo_z,
    input  logic       hi_o_q,
    input  logic       hi_c_q,
    input  logic       final_s7,
    input  logic       alu_o,
    input  logic       alu_z,
    input  logic       alu_c,
    output logic [3:0] wide_flags
);

    // Without a fix pass the live ALU result is the high pass itself.
    always_comb begin
        wide_flags         = 4'h0;
        wide_flags[FLAG_N] = final_s7;
        wide_flags[FLAG_Z] = lo_z & alu_z;
        if (in_fix) begin
            wide_flags[FLAG_C] = hi_c_q | alu_c;
            wide_flags[FLAG_O] = hi_o_q ^ alu_o;
        end else begin
            wide_flags[FLAG_C] = alu_c;
            wide_flags[FLAG_O] = alu_o;
        end
    end

endmodule

// File: rtl/d8_exec.sv
// rtl/d8_exec.sv - op sequencer over an external 8-bit ALU; ADDW/SUBW built only with D8_EXEC_WIDE_EN
module d8_exec
    import d8_pkg::*;
(
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_result,
    output logic [3:0]  resp_flags,
    output logic [3:0]  flags,
    output logic [2:0]  alu_ctrl,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic [7:0]  alu_s,
    input  logic        alu_n,
    input  logic        alu_o,
    input  logic        alu_z,
    input  logic        alu_c
);

    state_e     state;
    logic [2:0] op_q;
    logic [2:0] op_eff;
    logic [3:0] alu_flags;
    logic [3:0] narrow_flags;

    assign alu_flags    = {alu_n, alu_o, alu_z, alu_c};
    assign narrow_flags = (op_q == OP_NOP) ? flags : alu_flags;

    always_comb begin
        op_eff = req_op;
`ifndef D8_EXEC_WIDE_EN
        if (req_op == OP_ADDW || req_op == OP_SUBW)
            op_eff = OP_NOP;
`endif
    end

`ifdef D8_EXEC_WIDE_EN
    logic [7:0] a_hi_q;
    logic [7:0] b_hi_q;
    logic [7:0] lo_s_q;
    logic       lo_z_q;
    logic       lo_c_q;
    logic       hi_o_q;
    logic       hi_c_q;
    logic [3:0] wide_flags;

    d8_exec_wflags u_wflags (
        .in_fix     (state == FIX),
        .lo_z       (lo_z_q),
        .hi_o_q     (hi_o_q),
        .hi_c_q     (hi_c_q),
        .final_s7   (alu_s[7]),
        .alu_o      (alu_o),
        .alu_z      (alu_z),
        .alu_c      (alu_c),
        .wide_flags (wide_flags)
    );
`else
    logic unused_hi;
    assign unused_hi = ^{req_a[15:8], req_b[15:8]};
`endif

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_result <= 16'h0000;
            resp_flags  <= 4'h0;
            flags       <= 4'h0;
            alu_ctrl    <= ALU_NOP;
            alu_a       <= 8'h00;
            alu_b       <= 8'h00;
            op_q        <= OP_NOP;
`ifdef D8_EXEC_WIDE_EN
            a_hi_q      <= 8'h00;
            b_hi_q      <= 8'h00;
            lo_s_q      <= 8'h00;
            lo_z_q      <= 1'b0;
            lo_c_q      <= 1'b0;
            hi_o_q      <= 1'b0;
            hi_c_q      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q      <= op_eff;
                        alu_ctrl  <= alu_ctrl_for(op_eff);
                        alu_a     <= req_a[7:0];
                        alu_b     <= req_b[7:0];
`ifdef D8_EXEC_WIDE_EN
                        a_hi_q    <= req_a[15:8];
                        b_hi_q    <= req_b[15:8];
`endif
                        req_ready <= 1'b0;
                        state     <= LO;
                    end
                end
                LO: begin
`ifdef D8_EXEC_WIDE_EN
                    lo_s_q <= alu_s;
                    lo_z_q <= alu_z;
                    lo_c_q <= alu_c;
                    if (op_q == OP_ADDW || op_q == OP_SUBW) begin
                        alu_a <= a_hi_q;
                        alu_b <= b_hi_q;
                        state <= HI;
                    end else
`endif
                    begin
                        resp_result <= (op_q == OP_NOP || op_q == OP_CMP) ? 16'h0000 : {8'h00, alu_s};
                        resp_flags  <= narrow_flags;
                        flags       <= narrow_flags;
                        resp_valid  <= 1'b1;
                        alu_ctrl    <= ALU_NOP;
                        alu_a       <= 8'h00;
                        alu_b       <= 8'h00;
                        state       <= RESP;
                    end
                end
`ifdef D8_EXEC_WIDE_EN
                HI: begin
                    hi_o_q <= alu_o;
                    hi_c_q <= alu_c;
                    // Low-pass carry/borrow is folded in by a second pass on the high byte.
                    if (lo_c_q) begin
                        alu_a <= alu_s;
                        alu_b <= 8'h01;
                        state <= FIX;
                    end else begin
                        resp_result <= {alu_s, lo_s_q};
                        resp_flags  <= wide_flags;
                        flags       <= wide_flags;
                        resp_valid  <= 1'b1;
                        alu_ctrl    <= ALU_NOP;
                        alu_a       <= 8'h00;
                        alu_b       <= 8'h00;
                        state       <= RESP;
                    end
                end
                FIX: begin
                    resp_result <= {alu_s, lo_s_q};
                    resp_flags  <= wide_flags;
                    flags       <= wide_flags;
                    resp_valid  <= 1'b1;
                    alu_ctrl    <= ALU_NOP;
                    alu_a       <= 8'h00;
                    alu_b       <= 8'h00;
                    state       <= RESP;
                end
`endif
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    alu_ctrl   <= ALU_NOP;
                    alu_a      <= 8'h00;
                    alu_b      <= 8'h00;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_d8_exec.sv
// tb/tb_d8_exec.sv - self-checking bench for d8_exec with a behavioural 8-bit ALU beside it
module tb_d8_exec;

    localparam logic [2:0] NOP  = 3'b000;
    localparam logic [2:0] ADD  = 3'b001;
    localparam logic [2:0] SUB  = 3'b010;
    localparam logic [2:0] SHL  = 3'b011;
    localparam logic [2:0] SHR  = 3'b100;
    localparam logic [2:0] ADDW = 3'b101;
    localparam logic [2:0] SUBW = 3'b110;
    localparam logic [2:0] CMP  = 3'b111;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_result;
    logic [3:0]  resp_flags;
    logic [3:0]  flags;
    logic [2:0]  alu_ctrl;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [7:0]  alu_s;
    logic        alu_n;
    logic        alu_o;
    logic        alu_z;
    logic        alu_c;
    logic        alu_force;
    logic [3:0]  alu_force_flags;
    logic [8:0]  alu_t;

    int total = 0;
    int bad   = 0;
    logic [3:0] cur_flags;

    d8_exec dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_flags  (resp_flags),
        .flags       (flags),
        .alu_ctrl    (alu_ctrl),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_s       (alu_s),
        .alu_n       (alu_n),
        .alu_o       (alu_o),
        .alu_z       (alu_z),
        .alu_c       (alu_c)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // External ALU: c is carry for add, borrow for sub, shifted-out bit for shifts.
    always_comb begin
        alu_t = 9'h000;
        alu_s = 8'h00;
        alu_c = 1'b0;
        alu_o = 1'b0;
        case (alu_ctrl)
            3'b001: begin
                alu_t = {1'b0, alu_a} + {1'b0, alu_b};
                alu_s = alu_t[7:0];
                alu_c = alu_t[8];
                alu_o = (alu_a[7] == alu_b[7]) && (alu_t[7] != alu_a[7]);
            end
            3'b010: begin
                alu_t = {1'b0, alu_a} - {1'b0, alu_b};
                alu_s = alu_t[7:0];
                alu_c = alu_t[8];
                alu_o = (alu_a[7] != alu_b[7]) && (alu_t[7] != alu_a[7]);
            end
            3'b011: begin
                alu_s = {alu_a[6:0], 1'b0};
                alu_c = alu_a[7];
            end
            3'b100: begin
                alu_s = {1'b0, alu_a[7:1]};
                alu_c = alu_a[0];
            end
            default: ;
        endcase
        alu_n = alu_s[7];
        alu_z = (alu_s == 8'h00);
        if (alu_force)
            {alu_n, alu_o, alu_z, alu_c} = alu_force_flags;
    end

    typedef struct {
        logic [15:0] res;
        logic [3:0]  fl;
        int          lat;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [3:0]  fl;
        int          lat;
    } vec_t;

    // Reference: whole-word arithmetic on the operand width, not the two-pass scheme.
    function automatic exp_t ref_exec(input logic [2:0] op, input logic [15:0] a,
                                      input logic [15:0] b, input logic [3:0] fl_in);
        exp_t e;
        logic [2:0] k;
        int w, mask, ua, ub, sa, sb, st, r, lim;
        logic n, o, z, c;
        k = op;
`ifndef D8_EXEC_WIDE_EN
        if (k == ADDW || k == SUBW) k = NOP;
`endif
        e.res = 16'h0000;
        e.fl  = fl_in;
        e.lat = 2;
        if (k == NOP) return e;
        w    = (k == ADDW || k == SUBW) ? 16 : 8;
        mask = (1 << w) - 1;
        lim  = 1 << (w - 1);
        ua   = int'(a) & mask;
        ub   = int'(b) & mask;
        sa   = (ua >= lim) ? ua - (1 << w) : ua;
        sb   = (ub >= lim) ? ub - (1 << w) : ub;
        r = 0; o = 1'b0; c = 1'b0;
        case (k)
            ADD, ADDW: begin
                r = ua + ub; c = (r > mask); st = sa + sb; o = (st >= lim) || (st < -lim);
            end
            SUB, SUBW, CMP: begin
                r = ua - ub; c = (r < 0); st = sa - sb; o = (st >= lim) || (st < -lim);
            end
            SHL: begin r = ua * 2; c = (ua >= 128); end
            SHR: begin r = ua / 2; c = (ua % 2 == 1); end
            default: ;
        endcase
        r = r & mask;
        n = ((r >> (w - 1)) & 1) == 1;
        z = (r == 0);
        e.fl  = {n, o, z, c};
        e.res = (k == CMP) ? 16'h0000 : 16'(r);
        if (k == ADDW)
            e.lat = ((ua & 255) + (ub & 255) > 255) ? 4 : 3;
        else if (k == SUBW)
            e.lat = ((ua & 255) < (ub & 255)) ? 4 : 3;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] res, output logic [3:0] fl,
                          output logic [3:0] fl_reg, output int lat);
        int w;
        @(negedge sys_clk);
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge sys_clk);
            w++;
        end
        if (!req_ready) chk("req_ready_timeout", 32'(req_ready), 32'h1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(negedge sys_clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge sys_clk);
            lat++;
        end
        res    = resp_result;
        fl     = resp_flags;
        fl_reg = flags;
        resp_ready = 1'b1;
        @(negedge sys_clk);
        resp_ready = 1'b0;
    endtask

    task automatic wait_resp(input string name);
        int w;
        w = 0;
        while (!resp_valid && w < 20) begin
            @(negedge sys_clk);
            w++;
        end
        chk({name, "_resp_valid"}, 32'(resp_valid), 32'h1);
    endtask

    vec_t vecs[9];
    int   nvec;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] res;
        logic [3:0]  fl, fl_reg;
        int          lat;
        exp_t        e;
        logic [2:0]  rop;
        logic [15:0] ra, rb;

        sys_rst_n = 1'b0; req_valid = 1'b0; req_op = 3'b000; req_a = 16'h0; req_b = 16'h0;
        resp_ready = 1'b0; alu_force = 1'b0; alu_force_flags = 4'h0;

        repeat (3) @(negedge sys_clk);
        chk("rst_req_ready",  32'(req_ready),   32'h1);
        chk("rst_resp_valid", 32'(resp_valid),  32'h0);
        chk("rst_resp_result",32'(resp_result), 32'h0);
        chk("rst_resp_flags", 32'(resp_flags),  32'h0);
        chk("rst_flags",      32'(flags),       32'h0);
        chk("rst_alu_ctrl",   32'(alu_ctrl),    32'h0);
        chk("rst_alu_a",      32'(alu_a),       32'h0);
        chk("rst_alu_b",      32'(alu_b),       32'h0);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        chk("post_rst_req_ready", 32'(req_ready), 32'h1);

        vecs[0] = '{ADD,  16'h007F, 16'h0001, 16'h0080, 4'b1100, 2};
        vecs[1] = '{CMP,  16'h0005, 16'h0005, 16'h0000, 4'b0010, 2};
        vecs[2] = '{NOP,  16'h1234, 16'h5678, 16'h0000, 4'b0010, 2};
        vecs[3] = '{SUB,  16'h0003, 16'h0005, 16'h00FE, 4'b1001, 2};
        vecs[4] = '{SHL,  16'hAAC1, 16'h0000, 16'h0082, 4'b1001, 2};
        vecs[5] = '{SHR,  16'h0001, 16'h0000, 16'h0000, 4'b0011, 2};
`ifdef D8_EXEC_WIDE_EN
        vecs[6] = '{ADDW, 16'h00FF, 16'h0001, 16'h0100, 4'b0000, 4};
        vecs[7] = '{SUBW, 16'h0000, 16'h0001, 16'hFFFF, 4'b1001, 4};
        vecs[8] = '{ADDW, 16'h1234, 16'h0001, 16'h1235, 4'b0000, 3};
        nvec = 9;
`else
        vecs[6] = '{ADDW, 16'h00FF, 16'h0001, 16'h0000, 4'b0011, 2};
        vecs[7] = '{SUBW, 16'h0000, 16'h0001, 16'h0000, 4'b0011, 2};
        nvec = 8;
`endif
        for (int i = 0; i < nvec; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, fl, fl_reg, lat);
            chk($sformatf("vec%0d_result", i), 32'(res),    32'(vecs[i].res));
            chk($sformatf("vec%0d_rflags", i), 32'(fl),     32'(vecs[i].fl));
            chk($sformatf("vec%0d_flags",  i), 32'(fl_reg), 32'(vecs[i].fl));
            chk($sformatf("vec%0d_latency",i), 32'(lat),    32'(vecs[i].lat));
        end

        // Pass-by-pass ALU drive
        @(negedge sys_clk);
        req_valid = 1'b1;
`ifdef D8_EXEC_WIDE_EN
        req_op = ADDW; req_a = 16'h00FF; req_b = 16'h0001;
        @(negedge sys_clk);
        req_valid = 1'b0;
        chk("lo_pass", 32'({alu_ctrl, alu_a, alu_b}), 32'({3'b001, 8'hFF, 8'h01}));
        @(negedge sys_clk);
        chk("hi_pass", 32'({alu_ctrl, alu_a, alu_b}), 32'({3'b001, 8'h00, 8'h00}));
        @(negedge sys_clk);
        chk("fix_pass", 32'({alu_ctrl, alu_a, alu_b}), 32'({3'b001, 8'h00, 8'h01}));
        @(negedge sys_clk);
        chk("seq_resp_valid", 32'(resp_valid), 32'h1);
        chk("seq_result", 32'(resp_result), 32'h0100);
        cur_flags = 4'h0;
`else
        req_op = ADD; req_a = 16'h007F; req_b = 16'h0001;
        @(negedge sys_clk);
        req_valid = 1'b0;
        chk("lo_pass", 32'({alu_ctrl, alu_a, alu_b}), 32'({3'b001, 8'h7F, 8'h01}));
        @(negedge sys_clk);
        chk("seq_resp_valid", 32'(resp_valid), 32'h1);
        chk("seq_result", 32'(resp_result), 32'h0080);
        cur_flags = 4'hC;
`endif
        chk("resp_alu_idle", 32'({alu_ctrl, alu_a, alu_b}), 32'h0);
        resp_ready = 1'b1;
        @(negedge sys_clk);
        resp_ready = 1'b0;

        // Backpressure with a second request already pending
        req_valid = 1'b1; req_op = ADD; req_a = 16'h0010; req_b = 16'h0020;
        @(negedge sys_clk);
        req_op = SUB; req_a = 16'h0009; req_b = 16'h0004;
        wait_resp("bp1");
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_hold%0d", i),
                32'({resp_valid, req_ready, resp_flags, resp_result}), 32'({1'b1, 1'b0, 4'h0, 16'h0030}));
            @(negedge sys_clk);
        end
        resp_ready = 1'b1;
        @(negedge sys_clk);
        resp_ready = 1'b0;
        chk("bp_after_hs", 32'({resp_valid, req_ready}), 32'({1'b0, 1'b1}));
        @(negedge sys_clk);
        req_valid = 1'b0;
        chk("bp_second_accepted", 32'(req_ready), 32'h0);
        wait_resp("bp2");
        chk("bp2_result", 32'({resp_flags, resp_result}), 32'({4'h0, 16'h0005}));
        resp_ready = 1'b1;
        @(negedge sys_clk);
        resp_ready = 1'b0;

        // Flags preloaded to 0xA through the ALU, then a wide op
        alu_force = 1'b1; alu_force_flags = 4'hA;
        run_op(ADD, 16'h0001, 16'h0001, res, fl, fl_reg, lat);
        alu_force = 1'b0;
        chk("preload_result", 32'(res), 32'h0002);
        chk("preload_flags", 32'(fl_reg), 32'hA);
        run_op(ADDW, 16'h1234, 16'h0001, res, fl, fl_reg, lat);
`ifdef D8_EXEC_WIDE_EN
        chk("wide_after_preload", 32'({res, fl_reg, 8'(lat)}), 32'({16'h1235, 4'h0, 8'd3}));
`else
        chk("nowide_addw", 32'({res, fl_reg, 8'(lat)}), 32'({16'h0000, 4'hA, 8'd2}));
`endif

        // Reset mid-operation
        run_op(CMP, 16'h0005, 16'h0005, res, fl, fl_reg, lat);
        chk("pre_rst_flags", 32'(fl_reg), 32'h2);
        @(negedge sys_clk);
        req_valid = 1'b1; req_op = ADDW; req_a = 16'h00FF; req_b = 16'h0001;
        @(negedge sys_clk);
        req_valid = 1'b0;
`ifdef D8_EXEC_WIDE_EN
        @(negedge sys_clk);
`endif
        chk("midop_busy", 32'({req_ready, resp_valid}), 32'h0);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        chk("midrst_state", 32'({req_ready, resp_valid, flags, resp_flags}), 32'({1'b1, 1'b0, 4'h0, 4'h0}));
        chk("midrst_alu", 32'({alu_ctrl, alu_a, alu_b}), 32'h0);
        chk("midrst_result", 32'(resp_result), 32'h0);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        chk("midrst_release", 32'({req_ready, resp_valid}), 32'({1'b1, 1'b0}));
        cur_flags = 4'h0;

        for (int i = 0; i < 80; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = 16'($urandom);
            rb  = (i % 3 == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            e = ref_exec(rop, ra, rb, cur_flags);
            run_op(rop, ra, rb, res, fl, fl_reg, lat);
            chk($sformatf("rnd%0d_op%0d_result", i, rop), 32'(res), 32'(e.res));
            chk($sformatf("rnd%0d_op%0d_rflags", i, rop), 32'(fl), 32'(e.fl));
            chk($sformatf("rnd%0d_op%0d_flags", i, rop), 32'(fl_reg), 32'(e.fl));
            chk($sformatf("rnd%0d_op%0d_latency", i, rop), 32'(lat), 32'(e.lat));
            cur_flags = e.fl;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
